// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one 8-bit ALU among NUM_REQ
// requesters. One transaction is in flight at a time: IDLE grants and
// captures operands, EXEC registers the ALU result, and RESP holds the
// tagged result until the consumer takes it.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req_valid_i       per-requester request valid
//   req_a_i/req_b_i   packed 8-bit operands, requester k at [8k+7:8k]
//   req_op_i          packed 3-bit opcodes, requester k at [3k+2:3k]
//   req_ready_o       one-hot combinational grant (IDLE only)
//   resp_valid_o      result held on the response channel
//   resp_ready_i      consumer accepts the result
//   resp_data_o       registered ALU result
//   resp_id_o         index of the requester owning resp_data_o
//   busy_o            high whenever the FSM is not IDLE
//   resp_zero_o       (ALU_ARB_ZERO_FLAG_EN only) result == 0x00
//
// Optional feature macro: ALU_ARB_ZERO_FLAG_EN adds resp_zero_o.

module alu_arbiter_alu (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] op_i,
  output logic [7:0] y_o
);
  always_comb begin
    y_o = 8'h00;
    case (op_i)
      3'b000:  y_o = a_i + b_i;
      3'b001:  y_o = a_i - b_i;
      3'b010:  y_o = a_i << b_i[2:0];
      3'b011:  y_o = a_i >> b_i[2:0];
      3'b100:  y_o = a_i & b_i;
      3'b101:  y_o = a_i | b_i;
      3'b110:  y_o = a_i ^ b_i;
      default: y_o = {7'b0, (a_i == b_i)};
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [8*NUM_REQ-1:0]       req_a_i,
  input  logic [8*NUM_REQ-1:0]       req_b_i,
  input  logic [3*NUM_REQ-1:0]       req_op_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [7:0]                 resp_data_o,
  output logic [$clog2(NUM_REQ)-1:0] resp_id_o,
  output logic                       busy_o
`ifdef ALU_ARB_ZERO_FLAG_EN
  ,
  output logic                       resp_zero_o
`endif
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] id_q;
  logic [7:0]     a_q, b_q;
  logic [2:0]     op_q;
  logic [7:0]     resp_data_q;
  logic [IDW-1:0] resp_id_q;
  logic [7:0]     alu_y;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   scan;

  // Round-robin search: first valid index at or after ptr_q, wrapping.
  // scan is one bit wider than an index so ptr+i can be compared to NUM_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(i);
      if (scan >= (IDW+1)'(NUM_REQ)) scan = scan - (IDW+1)'(NUM_REQ);
      if (!gnt_any && req_valid_i[scan[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[IDW-1:0];
      end
    end
  end

  alu_arbiter_alu u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (alu_y)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Grant is gated by reset so nothing is offered while it is held.
  always_comb begin
    req_ready_o  = '0;
    if (state_q == IDLE && gnt_any && !reset)
      req_ready_o = NUM_REQ'(1) << gnt_idx;
    resp_valid_o = (state_q == RESP);
    busy_o       = (state_q != IDLE);
  end

  // Capture on grant, result on EXEC exit; pointer moves past the winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
    end else begin
      if (state_q == IDLE && gnt_any) begin
        a_q   <= req_a_i[8*gnt_idx +: 8];
        b_q   <= req_b_i[8*gnt_idx +: 8];
        op_q  <= req_op_i[3*gnt_idx +: 3];
        id_q  <= gnt_idx;
        ptr_q <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state_q == EXEC) begin
        resp_data_q <= alu_y;
        resp_id_q   <= id_q;
      end
    end
  end

  assign resp_data_o = resp_data_q;
  assign resp_id_o   = resp_id_q;

`ifdef ALU_ARB_ZERO_FLAG_EN
  logic resp_zero_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 resp_zero_q <= 1'b0;
    else if (state_q == EXEC)  resp_zero_q <= (alu_y == 8'h00);
  end
  assign resp_zero_o = resp_zero_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by a
// randomized phase, all compared against a behavioural reference model.
module tb_alu_arbiter;
  localparam int N = 4;

  logic             clk, rst;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_a, req_b;
  logic [3*N-1:0]   req_op;
  logic [N-1:0]     req_ready;
  logic             resp_valid, resp_ready, busy;
  logic [7:0]       resp_data;
  logic [1:0]       resp_id;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic             resp_zero;
`endif

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .reset        (rst),
    .req_valid_i  (req_valid),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_id_o    (resp_id),
    .busy_o       (busy)
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    .resp_zero_o  (resp_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference ALU in plain integer arithmetic.
  function automatic int ref_alu(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return (a * (1 << (b % 8))) % 256;
      3: return a / (1 << (b % 8));
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      default: return (a == b) ? 1 : 0;
    endcase
  endfunction

  // Next winner: first valid requester at or after the rotation point.
  function automatic int ref_grant(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[(ptr_m + i) % N]) return (ptr_m + i) % N;
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[8*k +: 8] = a;
    req_b[8*k +: 8] = b;
    req_op[3*k +: 3] = op;
  endtask

  // One full transaction starting in IDLE with inputs already driven.
  // stall = cycles the consumer withholds resp_ready; vld_after = request
  // valids driven once the grant has been taken.
  task automatic txn(input int stall, input logic [N-1:0] vld_after);
    int g, expv;
    #1;
    g = ref_grant(req_valid);
    chk("grant", 32'(req_ready), 32'(1) << g);
    expv = ref_alu(int'(req_a[8*g +: 8]), int'(req_b[8*g +: 8]), int'(req_op[3*g +: 3]));
    tick();
    ptr_m = (g + 1) % N;
    req_valid = vld_after;
    #1;
    chk("exec_busy", 32'(busy), 1);
    chk("exec_ready", 32'(req_ready), 0);
    chk("exec_rvalid", 32'(resp_valid), 0);
    tick();
    for (int s = 0; s <= stall; s++) begin
      resp_ready = (s == stall);
      #1;
      chk("resp_valid", 32'(resp_valid), 1);
      chk("resp_data", 32'(resp_data), expv);
      chk("resp_id", 32'(resp_id), g);
      chk("resp_ready_blk", 32'(req_ready), 0);
`ifdef ALU_ARB_ZERO_FLAG_EN
      chk("resp_zero", 32'(resp_zero), (expv == 0) ? 1 : 0);
`endif
      tick();
    end
    resp_ready = 1'b0;
    #1;
    chk("post_rvalid", 32'(resp_valid), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rvalid", 32'(resp_valid), 0);
    chk("rst_data", 32'(resp_data), 0);
    chk("rst_id", 32'(resp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    ptr_m = 0;
  endtask

  initial begin
    int g;
    logic [N-1:0] mask;
    rst = 1'b1;
    resp_ready = 1'b0;
    req_valid = '1;
    req_a = '0; req_b = '0; req_op = '0;
    for (int k = 0; k < N; k++)
      set_req(k, 8'($urandom), 8'($urandom), 3'($urandom));

    // Reset state, with every request valid.
    do_reset();

    // Single add from requester 2.
    req_valid = 4'b0100;
    set_req(2, 8'hF0, 8'h20, 3'b000);
    txn(0, 4'b0000);

    // Round-robin with all requesters continuously valid from reset.
    req_valid = '1;
    do_reset();
    for (int i = 0; i < 5; i++) txn(0, '1);

    // Backpressure: requester 0 subtract, others pile up during RESP.
    req_valid = 4'b0001;
    set_req(0, 8'h05, 8'h07, 3'b001);
    txn(5, '1);
    req_valid = '0;
    tick();

    // Operator sweep through requester 1.
    begin
      logic [2:0] ops [4];
      ops = '{3'b010, 3'b011, 3'b111, 3'b110};
      for (int i = 0; i < 4; i++) begin
        req_valid = 4'b0010;
        set_req(1, 8'h81, 8'h0B, ops[i]);
        txn(0, 4'b0000);
      end
    end

    // XOR producing zero and non-zero.
    req_valid = 4'b1000;
    set_req(3, 8'h33, 8'h33, 3'b110);
    txn(0, 4'b0000);
    req_valid = 4'b1000;
    set_req(3, 8'h33, 8'h32, 3'b110);
    txn(1, 4'b0000);

    // Randomized phase with idle gaps.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        #1;
        chk("idle_ready", 32'(req_ready), 0);
        chk("idle_busy", 32'(busy), 0);
        tick();
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++)
        set_req(k, 8'($urandom), 8'($urandom), 3'($urandom));
      req_valid = mask;
      txn($urandom_range(0, 2), mask);
    end

    // Reset during EXEC: transaction discarded, rotation restarts at 0.
    req_valid = 4'b1000;
    set_req(3, 8'h12, 8'h34, 3'b000);
    #1;
    g = ref_grant(req_valid);
    chk("mid_grant", 32'(req_ready), 32'(1) << g);
    tick();
    chk("mid_exec_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_rvalid", 32'(resp_valid), 0);
    chk("mid_rst_data", 32'(resp_data), 0);
    chk("mid_rst_id", 32'(resp_id), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    ptr_m = 0;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_no_resp", 32'(resp_valid), 0);
      tick();
    end
    req_valid = 4'b1010;
    set_req(1, 8'h40, 8'h02, 3'b011);
    txn(0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
